// File: rtl/parity_sched_pkg.sv
// Shared types, constants and the round-robin pick function for the parity scheduler.
package parity_sched_pkg;

  localparam int unsigned BEAT_W   = 3;
  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned MAX_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    OUT  = 2'd2
  } state_e;

  // First set valid bit at or above ptr, wrapping at n; only the low n lanes count.
  function automatic logic [MAX_ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0]  valid,
                                                  input logic [MAX_ID_W-1:0] ptr,
                                                  input int unsigned         n);
    logic [MAX_ID_W-1:0] pick;
    logic                found;
    logic [31:0]         idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + 32'(k)) % 32'(n);
      if (!found && (k < n) && valid[idx[MAX_ID_W-1:0]]) begin
        pick  = idx[MAX_ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/parity_sched_if.sv
// Requester beat lanes and the tagged result channel of the parity scheduler.
interface parity_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_parity;
  logic [ID_W-1:0]      res_id;

  modport master (
    output req_valid, req_data, req_last, res_ready,
    input  req_ready, res_valid, res_parity, res_id
  );

  modport slave (
    input  req_valid, req_data, req_last, res_ready,
    output req_ready, res_valid, res_parity, res_id
  );

endinterface

// File: rtl/parity_sched_xor3_parity.sv
// Shared combinational evaluator: parity of one 3-bit beat.
module xor3_parity
  import parity_sched_pkg::*;
(
  input  logic [BEAT_W-1:0] beat_i,
  output logic              parity_c_o
);

  assign parity_c_o = ^beat_i;

endmodule

// File: rtl/parity_sched.sv
// Round-robin scheduler sharing one xor3 evaluator; locks on a requester for a whole packet.
module parity_sched
  import parity_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic           clk,
  input  logic           rst_n,
  parity_sched_if.slave  bus
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               acc_q, acc_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               res_parity_q, res_parity_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;

  logic [BEAT_W-1:0]  beat;
  logic               beat_par_c;
  logic               fire_c;
  logic               last_c;
  logic [ID_W-1:0]    pick_c;

  // Only the granted lane reaches the evaluator, so ignored lanes cannot leak X.
  always_comb begin
    beat = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        beat = bus.req_data[i*BEAT_W +: BEAT_W];
      end
    end
  end

  xor3_parity u_xor3 (
    .beat_i     (beat),
    .parity_c_o (beat_par_c)
  );

  // req_ready_q is one-hot on the grant in BUSY, so masking selects that lane's handshake.
  assign fire_c = |(req_ready_q & bus.req_valid);
  assign last_c = |(req_ready_q & bus.req_last);
  assign pick_c = ID_W'(rr_pick(MAX_REQ'(bus.req_valid), MAX_ID_W'(rr_ptr_q), NUM_REQ));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    acc_d        = acc_q;
    req_ready_d  = req_ready_q;
    res_valid_d  = res_valid_q;
    res_parity_d = res_parity_q;
    res_id_d     = res_id_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_d     = pick_c;
          acc_d       = 1'b0;
          req_ready_d = NUM_REQ'(1) << pick_c;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (fire_c) begin
          if (last_c) begin
            res_parity_d = acc_q ^ beat_par_c;
            res_id_d     = grant_q;
            res_valid_d  = 1'b1;
            req_ready_d  = '0;
            state_d      = OUT;
          end else begin
            acc_d = acc_q ^ beat_par_c;
          end
        end
      end
      OUT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          rr_ptr_d    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        req_ready_d = '0;
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      acc_q        <= 1'b0;
      req_ready_q  <= '0;
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
      res_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      acc_q        <= acc_d;
      req_ready_q  <= req_ready_d;
      res_valid_q  <= res_valid_d;
      res_parity_q <= res_parity_d;
      res_id_q     <= res_id_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_parity = res_parity_q;
  assign bus.res_id     = res_id_q;

endmodule

// File: tb/tb_parity_sched.sv
// Directed bench for parity_sched with a result scoreboard keyed by requester id.
module tb_parity_sched;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            parity;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t sb_q[$];

  parity_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  parity_sched #(.NUM_REQ(NUM_REQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs set before the call are what the coming posedge sees; a handshake then retires one entry.
  task automatic step();
    exp_t e;
    if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_underflow: observed result id %0d with no expected entry", bus.res_id);
      end else begin
        e = sb_q.pop_front();
        check("sb_id", 32'(bus.res_id), 32'(e.id));
        check("sb_parity", 32'(bus.res_parity), 32'(e.parity));
      end
    end
    @(negedge clk);
  endtask

  task automatic lane(input int i, input logic v, input logic [2:0] d, input logic l);
    bus.req_valid[i]       = v;
    bus.req_data[3*i +: 3] = d;
    bus.req_last[i]        = l;
  endtask

  task automatic push(input int id, input logic p);
    exp_t e;
    e.id     = ID_W'(id);
    e.parity = p;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = 'x;
    bus.req_last  = 'x;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_parity", 32'(bus.res_parity), 32'd0);
    check("rst_res_id", 32'(bus.res_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single-beat packet from req0: grant, accept, result, back to idle.
    bus.res_ready = 1'b1;
    lane(0, 1'b1, 3'b011, 1'b1);
    push(0, 1'b0);
    step();
    check("t1_ready_c1", 32'(bus.req_ready), 32'b0001);
    check("t1_resv_c1", 32'(bus.res_valid), 32'd0);
    step();
    check("t1_resv_c2", 32'(bus.res_valid), 32'd1);
    check("t1_par_c2", 32'(bus.res_parity), 32'd0);
    check("t1_id_c2", 32'(bus.res_id), 32'd0);
    check("t1_ready_c2", 32'(bus.req_ready), 32'd0);
    lane(0, 1'b0, 3'bxxx, 1'bx);
    step();
    check("t1_resv_c3", 32'(bus.res_valid), 32'd0);

    // Three back-to-back beats from req2 with X on every other lane.
    lane(2, 1'b1, 3'b001, 1'b0);
    push(2, 1'b0);
    step();
    check("t2_ready_c1", 32'(bus.req_ready), 32'b0100);
    step();
    check("t2_ready_c2", 32'(bus.req_ready), 32'b0100);
    lane(2, 1'b1, 3'b111, 1'b0);
    step();
    lane(2, 1'b1, 3'b110, 1'b1);
    step();
    check("t2_resv_c4", 32'(bus.res_valid), 32'd1);
    check("t2_id_c4", 32'(bus.res_id), 32'd2);
    lane(2, 1'b0, 3'bxxx, 1'bx);
    step();

    // All four requesters contend from rr_ptr=0: served 0,1,2,3,0.
    do_reset();
    lane(0, 1'b1, 3'b001, 1'b1);
    lane(1, 1'b1, 3'b011, 1'b1);
    lane(2, 1'b1, 3'b111, 1'b1);
    lane(3, 1'b1, 3'b000, 1'b1);
    push(0, 1'b1); push(1, 1'b0); push(2, 1'b1); push(3, 1'b0); push(0, 1'b1);
    for (int k = 0; k < 14; k++) step();
    bus.req_valid = '0;
    step();
    step();
    check("t3_drained", 32'(sb_q.size()), 32'd0);
    check("t3_idle_ready", 32'(bus.req_ready), 32'd0);

    // Result from req1 held under backpressure while req3 waits.
    bus.res_ready = 1'b0;
    lane(1, 1'b1, 3'b100, 1'b1);
    push(1, 1'b1);
    step();
    step();
    lane(1, 1'b0, 3'bxxx, 1'bx);
    lane(3, 1'b1, 3'b010, 1'b1);
    push(3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_hold_valid", 32'(bus.res_valid), 32'd1);
      check("t4_hold_par", 32'(bus.res_parity), 32'd1);
      check("t4_hold_id", 32'(bus.res_id), 32'd1);
      check("t4_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    step();
    check("t4_idle_ready", 32'(bus.req_ready), 32'd0);
    step();
    check("t4_grant3", 32'(bus.req_ready), 32'b1000);
    step();
    lane(3, 1'b0, 3'bxxx, 1'bx);
    step();

    // req0 stalls mid-packet; lock holds against a valid req1.
    lane(0, 1'b1, 3'b100, 1'b0);
    lane(1, 1'b1, 3'b001, 1'b1);
    push(0, 1'b1);
    push(1, 1'b1);
    step();
    check("t5_grant0", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_lock", 32'(bus.req_ready), 32'b0001);
    end
    lane(0, 1'b1, 3'b010, 1'b0);
    step();
    lane(0, 1'b1, 3'b001, 1'b1);
    step();
    check("t5_resv", 32'(bus.res_valid), 32'd1);
    lane(0, 1'b0, 3'bxxx, 1'bx);
    step();
    step();
    check("t5_grant1", 32'(bus.req_ready), 32'b0010);
    step();
    lane(1, 1'b0, 3'bxxx, 1'bx);
    step();

    // Reset mid-packet after two beats; nothing emitted, state and acc start over.
    lane(2, 1'b1, 3'b001, 1'b0);
    step();
    step();
    lane(2, 1'b1, 3'b011, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_resv", 32'(bus.res_valid), 32'd0);
    check("t6_rst_ready", 32'(bus.req_ready), 32'd0);
    lane(2, 1'b0, 3'bxxx, 1'bx);
    @(negedge clk);
    rst_n = 1'b1;
    lane(0, 1'b1, 3'b011, 1'b1);
    lane(1, 1'b1, 3'b110, 1'b1);
    push(0, 1'b0);
    push(1, 1'b0);
    step();
    check("t6_grant0", 32'(bus.req_ready), 32'b0001);
    step();
    lane(0, 1'b0, 3'bxxx, 1'bx);
    step();
    step();
    check("t6_grant1", 32'(bus.req_ready), 32'b0010);
    step();
    lane(1, 1'b0, 3'bxxx, 1'bx);
    step();
    step();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
